// File: rtl/gvt_reducer.sv
// Pipelined masked min-reduction of per-channel local virtual times into a global virtual time,
// with argmin index, fill tracking, a monotonic guard and a change strobe.
module gvt_reducer #(
  parameter int N_CH        = 16,
  parameter int VT_W        = 64,
  parameter int LVL_PER_REG = 1,
  parameter int OUT_STAGES  = 2,
  parameter int MONOTONIC   = 1,
  parameter int IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*VT_W-1:0]   lvt,
  input  logic [N_CH-1:0]        lvt_vld,
  output logic [VT_W-1:0]        gvt,
  output logic [IDX_W-1:0]       gvt_tile,
  output logic                   gvt_vld,
  output logic                   gvt_idle,
  output logic                   gvt_upd,
  output logic                   gvt_regress
);

  localparam int D = (N_CH > 1) ? $clog2(N_CH) : 0;
  localparam int P = 1 << D;
  localparam int S = (D + LVL_PER_REG - 1) / LVL_PER_REG;
  localparam int L = S + OUT_STAGES + 1;

  typedef struct packed {
    logic [VT_W-1:0]  vt;
    logic [IDX_W-1:0] idx;
  } node_t;

  localparam node_t NODE_MAX = '{vt: {VT_W{1'b1}}, idx: '0};

  // lvl_n[l][j] is node j after tree level l (registered or not); level 0 holds the leaves.
  node_t lvl_n  [D+1][P];
  node_t pipe_n [OUT_STAGES+1];

  for (genvar g = 0; g < P; g++) begin : g_leaf
    if (g < N_CH) begin : g_real
      assign lvl_n[0][g] = '{vt:  lvt_vld[g] ? lvt[g*VT_W +: VT_W] : {VT_W{1'b1}},
                             idx: IDX_W'(g)};
    end else begin : g_pad
      assign lvl_n[0][g] = NODE_MAX;
    end
  end

  for (genvar l = 1; l <= D; l++) begin : g_lvl
    for (genvar j = 0; j < (P >> l); j++) begin : g_node
      node_t node_d;
      // Left child wins ties so the lowest channel index is reported.
      assign node_d = (lvl_n[l-1][2*j].vt <= lvl_n[l-1][2*j+1].vt) ? lvl_n[l-1][2*j]
                                                                     : lvl_n[l-1][2*j+1];
      if ((l % LVL_PER_REG == 0) || (l == D)) begin : g_reg
        node_t node_q;
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk) begin
          if (rst) node_q <= NODE_MAX;
          else     node_q <= node_d;
        end
        assign lvl_n[l][j] = node_q;
      end else begin : g_comb
        assign lvl_n[l][j] = node_d;
      end
    end
    for (genvar j = (P >> l); j < P; j++) begin : g_unused
      assign lvl_n[l][j] = NODE_MAX;
    end
  end

  assign pipe_n[0] = lvl_n[D][0];

  for (genvar k = 0; k < OUT_STAGES; k++) begin : g_out
    node_t out_q;
    always_ff @(posedge clk) begin
      if (rst) out_q <= NODE_MAX;
      else     out_q <= pipe_n[k];
    end
    assign pipe_n[k+1] = out_q;
  end

  node_t            cand;
  logic [L-1:0]     fill_q, fill_d;
  logic [VT_W-1:0]  gvt_q, gvt_d;
  logic [IDX_W-1:0] tile_q, tile_d;
  logic             upd_q, upd_d;
  logic             regress_q, regress_d;

  assign cand = pipe_n[OUT_STAGES];

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    fill_d    = L'({fill_q, 1'b1});
    gvt_d     = gvt_q;
    tile_d    = tile_q;
    regress_d = regress_q;
    if (!fill_q[L-1] || (MONOTONIC == 0) || (cand.vt >= gvt_q)) begin
      gvt_d  = cand.vt;
      tile_d = cand.idx;
    end else begin
      regress_d = 1'b1;
    end
    // Strobe only when the register about to be valid actually changes value.
    upd_d = fill_d[L-1] && (gvt_d != gvt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q    <= '0;
      gvt_q     <= '0;
      tile_q    <= '0;
      upd_q     <= 1'b0;
      regress_q <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      gvt_q     <= gvt_d;
      tile_q    <= tile_d;
      upd_q     <= upd_d;
      regress_q <= regress_d;
    end
  end

  assign gvt         = gvt_q;
  assign gvt_tile    = tile_q;
  assign gvt_vld     = fill_q[L-1];
  assign gvt_idle    = (gvt_q == {VT_W{1'b1}});
  assign gvt_upd     = upd_q;
  assign gvt_regress = regress_q;

endmodule

// File: tb/tb_gvt_reducer.sv
// Scoreboard bench for gvt_reducer: four geometries share one LVT bus; a monitor checks every cycle
// against a masked-min reference plus a guard model, and directed checks pin hand-computed values.
module tb_gvt_reducer;

  localparam int NC = 16;
  localparam int VW = 16;
  localparam logic [VW-1:0] VMAX = 16'hFFFF;

  // Geometries: a=(16,1,2,mono) b=(16,3,0,free) c=(5,2,2,free) d=(1,1,0,mono)
  localparam int LAT [4] = '{7, 3, 5, 1};
  localparam int NCH [4] = '{16, 16, 5, 1};
  localparam int MONO[4] = '{1, 0, 0, 1};

  logic clk = 1'b0;
  logic rst;
  logic [NC*VW-1:0] lvt;
  logic [NC-1:0]    lvt_vld;

  logic [VW-1:0] o_gvt [4];
  logic [3:0]    o_tile[4];
  logic          o_vld [4];
  logic          o_idle[4];
  logic          o_upd [4];
  logic          o_reg [4];
  logic [3:0]    tile_a, tile_b;
  logic [2:0]    tile_c;
  logic [0:0]    tile_d;

  assign o_tile[0] = tile_a;
  assign o_tile[1] = tile_b;
  assign o_tile[2] = {1'b0, tile_c};
  assign o_tile[3] = {3'b000, tile_d};

  gvt_reducer #(.N_CH(16), .VT_W(VW), .LVL_PER_REG(1), .OUT_STAGES(2), .MONOTONIC(1)) u_a (
    .clk(clk), .rst(rst), .lvt(lvt), .lvt_vld(lvt_vld),
    .gvt(o_gvt[0]), .gvt_tile(tile_a), .gvt_vld(o_vld[0]), .gvt_idle(o_idle[0]),
    .gvt_upd(o_upd[0]), .gvt_regress(o_reg[0]));

  gvt_reducer #(.N_CH(16), .VT_W(VW), .LVL_PER_REG(3), .OUT_STAGES(0), .MONOTONIC(0)) u_b (
    .clk(clk), .rst(rst), .lvt(lvt), .lvt_vld(lvt_vld),
    .gvt(o_gvt[1]), .gvt_tile(tile_b), .gvt_vld(o_vld[1]), .gvt_idle(o_idle[1]),
    .gvt_upd(o_upd[1]), .gvt_regress(o_reg[1]));

  gvt_reducer #(.N_CH(5), .VT_W(VW), .LVL_PER_REG(2), .OUT_STAGES(2), .MONOTONIC(0)) u_c (
    .clk(clk), .rst(rst), .lvt(lvt[5*VW-1:0]), .lvt_vld(lvt_vld[4:0]),
    .gvt(o_gvt[2]), .gvt_tile(tile_c), .gvt_vld(o_vld[2]), .gvt_idle(o_idle[2]),
    .gvt_upd(o_upd[2]), .gvt_regress(o_reg[2]));

  gvt_reducer #(.N_CH(1), .VT_W(VW), .LVL_PER_REG(1), .OUT_STAGES(0), .MONOTONIC(1)) u_d (
    .clk(clk), .rst(rst), .lvt(lvt[VW-1:0]), .lvt_vld(lvt_vld[0:0]),
    .gvt(o_gvt[3]), .gvt_tile(tile_d), .gvt_vld(o_vld[3]), .gvt_idle(o_idle[3]),
    .gvt_upd(o_upd[3]), .gvt_regress(o_reg[3]));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][VW-1:0] vt;
    logic [3:0][3:0]    idx;
  } exp_t;

  exp_t sbq[$];
  int   rd[4];
  int   cyc;
  int   n_err;
  int   n_chk;

  logic [VW-1:0] h_vt  [4];
  logic [3:0]    h_tile[4];
  logic          m_upd [4];
  logic          m_reg [4];
  logic          m_vld [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: masked minimum with lowest-index argmin over each DUT's channel count.
  function automatic exp_t ref_min(input logic [NC*VW-1:0] v, input logic [NC-1:0] m);
    exp_t r;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      logic [VW-1:0] best;
      logic [VW-1:0] x;
      int            bi;
      best = m[0] ? v[VW-1:0] : VMAX;
      bi   = 0;
      for (int i = 1; i < NCH[d]; i++) begin
        x = m[i] ? v[i*VW +: VW] : VMAX;
        if (x < best) begin
          best = x;
          bi   = i;
        end
      end
      r.vt[d]  = best;
      r.idx[d] = 4'(bi);
    end
    return r;
  endfunction

  task automatic step();
    if (!rst) sbq.push_back(ref_min(lvt, lvt_vld));
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [VW-1:0] v);
    for (int i = 0; i < NC; i++) lvt[i*VW +: VW] = v;
  endtask

  initial begin
    cyc   = 0;
    n_err = 0;
    n_chk = 0;
    for (int d = 0; d < 4; d++) begin
      rd[d] = 0; h_vt[d] = '0; h_tile[d] = '0; m_upd[d] = 1'b0; m_reg[d] = 1'b0; m_vld[d] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0;
      sbq.delete();
      for (int d = 0; d < 4; d++) begin
        rd[d] = 0; m_reg[d] = 1'b0; m_vld[d] = 1'b0;
      end
    end else begin
      cyc++;
    end
  end

  // Monitor: pops one expected tree result per valid output cycle and applies the guard model.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      logic [VW-1:0] c_vt;
      logic [3:0]    c_idx;
      if (cyc >= LAT[d]) begin
        if (rd[d] >= sbq.size()) begin
          n_chk++;
          n_err++;
          $display("FAIL u%0d_scoreboard: got empty queue expected an entry at %0t", d, $time);
        end else begin
          c_vt  = sbq[rd[d]].vt[d];
          c_idx = sbq[rd[d]].idx[d];
          rd[d]++;
          if (!m_vld[d] || (MONO[d] == 0) || (c_vt >= h_vt[d])) begin
            m_upd[d]  = (c_vt != h_vt[d]);
            h_vt[d]   = c_vt;
            h_tile[d] = c_idx;
          end else begin
            m_upd[d] = 1'b0;
            m_reg[d] = 1'b1;
          end
          m_vld[d] = 1'b1;
        end
      end else begin
        h_vt[d]   = (cyc == 0) ? '0 : VMAX;
        h_tile[d] = '0;
        m_upd[d]  = 1'b0;
        m_vld[d]  = 1'b0;
      end
      check($sformatf("u%0d_vld", d),     64'(o_vld[d]),  64'(m_vld[d]));
      check($sformatf("u%0d_gvt", d),     64'(o_gvt[d]),  64'(h_vt[d]));
      check($sformatf("u%0d_tile", d),    64'(o_tile[d]), 64'(h_tile[d]));
      check($sformatf("u%0d_upd", d),     64'(o_upd[d]),  64'(m_upd[d]));
      check($sformatf("u%0d_regress", d), 64'(o_reg[d]),  64'(m_reg[d]));
      check($sformatf("u%0d_idle", d),    64'(o_idle[d]), 64'(h_vt[d] == VMAX));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    lvt_vld = '1;
    for (int i = 0; i < NC; i++) lvt[i*VW +: VW] = VW'(100 + i);
    repeat (3) step();
    rst = 1'b0;

    // Fill: L=7 on u_a
    repeat (6) step();
    check("fill_pre_vld", 64'(o_vld[0]), 64'd0);
    step();
    check("fill_vld",  64'(o_vld[0]),  64'd1);
    check("fill_gvt",  64'(o_gvt[0]),  64'd100);
    check("fill_tile", 64'(o_tile[0]), 64'd0);
    check("fill_upd",  64'(o_upd[0]),  64'd1);
    step();
    check("fill_upd_once", 64'(o_upd[0]), 64'd0);

    // Mask/tie
    set_all(VW'(150));
    lvt[5*VW +: VW] = VW'(140);
    lvt[9*VW +: VW] = VW'(140);
    repeat (7) step();
    check("tie_gvt",  64'(o_gvt[0]),  64'd140);
    check("tie_tile", 64'(o_tile[0]), 64'd5);
    lvt_vld[5] = 1'b0;
    repeat (7) step();
    check("mask_tile", 64'(o_tile[0]), 64'd9);
    check("mask_gvt",  64'(o_gvt[0]),  64'd140);
    check("mask_upd",  64'(o_upd[0]),  64'd0);

    // Monotonic guard vs free-running follow
    lvt_vld = '1;
    set_all(VW'(200));
    repeat (8) step();
    check("mono_base", 64'(o_gvt[0]), 64'd200);
    lvt[3*VW +: VW] = VW'(150);
    step();
    lvt[3*VW +: VW] = VW'(200);
    repeat (2) step();
    check("free_gvt", 64'(o_gvt[1]), 64'd150);
    check("free_upd", 64'(o_upd[1]), 64'd1);
    repeat (6) step();
    check("mono_hold",    64'(o_gvt[0]), 64'd200);
    check("mono_regress", 64'(o_reg[0]), 64'd1);
    check("single_clean", 64'(o_reg[3]), 64'd0);

    // Idle and re-entry
    lvt_vld = '0;
    repeat (8) step();
    check("idle_gvt",  64'(o_gvt[0]),  64'(VMAX));
    check("idle_flag", 64'(o_idle[0]), 64'd1);
    lvt_vld = '1;
    set_all(VW'(300));
    repeat (8) step();
    check("reentry_regress", 64'(o_reg[3]), 64'd1);
    check("reentry_hold",    64'(o_gvt[3]), 64'(VMAX));

    // Random streams, mid-run reset, more random
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 200; t++) begin
        for (int i = 0; i < NC; i++) begin
          lvt[i*VW +: VW] = ($urandom_range(0, 7) == 0) ? VMAX : VW'($urandom_range(0, 40));
          lvt_vld[i]      = ($urandom_range(0, 4) != 0);
        end
        step();
      end
      if (r == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_gvt",     64'(o_gvt[0]),  64'd0);
        check("rst_tile",    64'(o_tile[0]), 64'd0);
        check("rst_vld",     64'(o_vld[0]),  64'd0);
        check("rst_upd",     64'(o_upd[0]),  64'd0);
        check("rst_regress", 64'(o_reg[0]),  64'd0);
      end
    end

    repeat (10) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
